// File: rtl/gray_decoder.sv
// gray_decoder: registered Gray-to-binary decoder with valid/ready handshake.
// Optional single-step checker, enabled by `define GRAY_DECODER_STEP_CHECK_EN.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   gray_in, in_valid   input word and its valid
//   in_ready            word accepted this cycle (= !out_valid || out_ready)
//   bin_out, out_valid  decoded word and its valid (latency 1)
//   out_ready           downstream accepts the result
//   step_err            result broke the one-bit-step rule
//   err_count           saturating count of step errors (8 bits)
module gray_decoder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] bin_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             step_err,
  output logic [7:0]       err_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             accept;
  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] bin_q;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL: begin
        if (accept)         state_d = FULL;
        else if (out_ready) state_d = EMPTY;
      end
    endcase
  end

  always_comb begin
    out_valid = (state_q == FULL);
    in_ready  = (state_q == EMPTY) || out_ready;
  end

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin_d = gray_in;
    for (int s = 1; s < WIDTH; s++) begin
      bin_d = bin_d ^ (gray_in >> s);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         bin_q <= '0;
    else if (accept) bin_q <= bin_d;
  end

  assign bin_out = bin_q;

`ifdef GRAY_DECODER_STEP_CHECK_EN
  logic [WIDTH-1:0] ref_q;
  logic             have_ref_q;
  logic             err_q;
  logic [7:0]       cnt_q;
  logic [WIDTH-1:0] diff;
  logic             one_bit;
  logic             step_bad;

  // Exactly one differing bit: non-zero and a power of two.
  always_comb begin
    diff     = gray_in ^ ref_q;
    one_bit  = (diff != '0) &&
               ((diff & (diff - WIDTH'(1))) == '0);
    step_bad = have_ref_q && !one_bit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q      <= '0;
      have_ref_q <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else if (accept) begin
      ref_q      <= gray_in;
      have_ref_q <= 1'b1;
      err_q      <= step_bad;
      if (step_bad && cnt_q != 8'hFF)
        cnt_q <= cnt_q + 8'd1;
    end
  end

  assign step_err  = err_q;
  assign err_count = cnt_q;
`else
  assign step_err  = 1'b0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_gray_decoder.sv
// tb_gray_decoder: directed self-checking bench for gray_decoder.
// Expectations follow the build's step-checker setting.
module tb_gray_decoder;

`ifdef GRAY_DECODER_STEP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] gray_in;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] bin_out;
  logic       out_valid;
  logic       out_ready;
  logic       step_err;
  logic [7:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;

  gray_decoder #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .gray_in   (gray_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin_out   (bin_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .step_err  (step_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    out_ready = 1'b1; gray_in = 4'h0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1;
    out_ready = 1'b0; gray_in = 4'b0101;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid got %b exp 0", out_valid);
    end
    n_checks++;
    if (bin_out !== 4'h0) begin
      n_fail++; $display("FAIL reset_bin got %h exp 0", bin_out);
    end
    n_checks++;
    if (step_err !== 1'b0 || err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_err got %b/%0d exp 0/0", step_err, err_count);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready);
    end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_basic();
    logic [3:0] g [4] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      gray_in = g[i]; in_valid = 1'b1;
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || bin_out !== 4'(i) || step_err !== 1'b0) begin
        n_fail++;
        $display("FAIL basic[%0d] got v=%b b=%h e=%b exp v=1 b=%h e=0",
                 i, out_valid, bin_out, step_err, 4'(i));
      end
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_drain got %b exp 0", out_valid);
    end
  endtask

  task automatic test_full_count();
    logic [3:0] g [17] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5,
                           4'h4, 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB,
                           4'h9, 4'h8, 4'h0};
    do_reset();
    for (int i = 0; i < 17; i++) begin
      gray_in = g[i]; in_valid = 1'b1;
      tick();
      n_checks++;
      if (bin_out !== 4'(i % 16) || step_err !== 1'b0) begin
        n_fail++;
        $display("FAIL count[%0d] got b=%h e=%b exp b=%h e=0",
                 i, bin_out, step_err, 4'(i % 16));
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (err_count !== 8'd0) begin
      n_fail++; $display("FAIL count_errs got %0d exp 0", err_count);
    end
  endtask

  task automatic test_step_violation();
    logic [3:0] g  [3] = '{4'b0000, 4'b0011, 4'b0011};
    logic [3:0] eb [3] = '{4'h0, 4'h2, 4'h2};
    logic       ee [3] = '{1'b0, CHK, CHK};
    logic [7:0] ec [3] = '{8'd0, CHK ? 8'd1 : 8'd0, CHK ? 8'd2 : 8'd0};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      gray_in = g[i]; in_valid = 1'b1;
      tick();
      n_checks++;
      if (bin_out !== eb[i] || step_err !== ee[i] || err_count !== ec[i]) begin
        n_fail++;
        $display("FAIL step[%0d] got b=%h e=%b c=%0d exp b=%h e=%b c=%0d",
                 i, bin_out, step_err, err_count, eb[i], ee[i], ec[i]);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    gray_in = 4'b0000; in_valid = 1'b1;
    tick();
    out_ready = 1'b0;
    gray_in = 4'b1111;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_in_ready got %b exp 0", in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || bin_out !== 4'h0 ||
          step_err !== 1'b0 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d] got v=%b b=%h e=%b r=%b exp 1/0/0/0",
                 i, out_valid, bin_out, step_err, in_ready);
      end
      gray_in = 4'b0001;
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || bin_out !== 4'h1 || step_err !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release got v=%b b=%h e=%b exp 1/1/0",
               out_valid, bin_out, step_err);
    end
    gray_in = 4'b0011;
    tick();
    n_checks++;
    if (bin_out !== 4'h2 || step_err !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_next got b=%h e=%b exp 2/0", bin_out, step_err);
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_drain got %b exp 0", out_valid);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    gray_in = 4'b0000; in_valid = 1'b1;
    tick();
    for (int i = 1; i <= 300; i++) begin
      gray_in = (i % 2 == 1) ? 4'b0011 : 4'b0000;
      tick();
      if (i == 254 || i == 255) begin
        n_checks++;
        if (err_count !== (CHK ? 8'(i) : 8'd0)) begin
          n_fail++;
          $display("FAIL sat_at_%0d got %0d exp %0d",
                   i, err_count, CHK ? i : 0);
        end
      end
    end
    n_checks++;
    if (err_count !== (CHK ? 8'd255 : 8'd0) || step_err !== CHK) begin
      n_fail++;
      $display("FAIL sat_final got c=%0d e=%b exp c=%0d e=%b",
               err_count, step_err, CHK ? 255 : 0, CHK);
    end
    rst = 1'b1; gray_in = 4'b0011; out_ready = 1'b0;
    tick();
    rst = 1'b0; out_ready = 1'b1;
    n_checks++;
    if (out_valid !== 1'b0 || err_count !== 8'd0 || bin_out !== 4'h0) begin
      n_fail++;
      $display("FAIL sat_reset got v=%b c=%0d b=%h exp 0/0/0",
               out_valid, err_count, bin_out);
    end
    gray_in = 4'b0101;
    tick();
    n_checks++;
    if (bin_out !== 4'h6 || step_err !== 1'b0 || err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL post_reset_first got b=%h e=%b c=%0d exp 6/0/0",
               bin_out, step_err, err_count);
    end
    gray_in = 4'b0100;
    tick();
    n_checks++;
    if (bin_out !== 4'h7 || step_err !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_step got b=%h e=%b exp 7/0",
               bin_out, step_err);
    end
    gray_in = 4'b0100;
    tick();
    n_checks++;
    if (step_err !== CHK || err_count !== (CHK ? 8'd1 : 8'd0)) begin
      n_fail++;
      $display("FAIL post_reset_repeat got e=%b c=%0d exp %b/%0d",
               step_err, err_count, CHK, CHK ? 1 : 0);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0;
    out_ready = 1'b1; gray_in = 4'h0;
    test_reset();
    test_basic();
    test_full_count();
    test_step_violation();
    test_backpressure();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
